qea_host_sequencer: RTL and testbench
=====================================

QEA_HOST_SEQUENCER -- requirements
Module: qea_host_sequencer

Interface
REQ-001 SHALL have parameter PE_NUM, default 4, number of PEs (power of two, >=2).
REQ-002 SHALL have parameter STATE_DATA_WIDTH, default 64, width of one complex amplitude per PE.
REQ-003 SHALL have parameter STATE_ADDR_WIDTH, default 16, state RAM address width.
REQ-004 SHALL have parameter GATE_CONTEXT_DATA_WIDTH, default 64, context word width.
REQ-005 SHALL have parameter GATE_CONTEXT_ADDR_WIDTH, default 16, context address width.
REQ-006 SHALL have parameter MAX_QBIT_WIDTH, default 6, qubit-count field width.
REQ-007 SHALL have parameter CYC_WIDTH, default 32, execution-cycle counter width.
REQ-008 SHALL have ports: clk  in  1  sole clock. rst  in  1  reset.
REQ-009 SHALL have one clock; reset is asynchronous and active-high.
REQ-010 SHALL have host ports: i_go  in  1  start pulse. i_qbit_num  in  MAX_QBIT_WIDTH  qubit count. i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context word count.
REQ-011 SHALL have ports: i_ctx_valid/o_ctx_ready  in/out  1  context stream handshake. i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  word.
REQ-012 SHALL have ports: i_st_valid/o_st_ready  in/out  1  initial state handshake. i_st_data  in  PE_NUM*STATE_DATA_WIDTH  row.
REQ-013 SHALL have ports: o_rd_valid/i_rd_ready  out/in  1  readback handshake. o_rd_data  out  PE_NUM*STATE_DATA_WIDTH  row.
REQ-014 SHALL have ports: o_busy, o_done, o_error  out  1  status. o_exec_cycles  out  CYC_WIDTH  cycles from o_qea_start to i_qea_complete.
REQ-015 SHALL have QEA ports: o_qea_start  out  1. o_qea_qbit_num  out  MAX_QBIT_WIDTH. o_ctx_en, o_ctx_wea  out  1. o_ctx_addr, o_ctx_data  out  ctx widths. o_state_ena, o_state_wea  out  PE_NUM. o_state_addra  out  STATE_ADDR_WIDTH. o_state_dina  out  PE_NUM*STATE_DATA_WIDTH. i_qea_complete  in  1. i_qea_state_dout  in  PE_NUM*STATE_DATA_WIDTH.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD_CTX -> LOAD_ST -> START -> RUN -> RD_REQ -> RD_WAIT -> RD_OUT -> DONE -> IDLE.
REQ-017 SHALL accept i_go only in IDLE or DONE; latch i_qbit_num and i_ins_num; ignore i_go elsewhere.
REQ-018 SHALL, on i_go with qbit_num < log2(PE_NUM) or > STATE_ADDR_WIDTH+log2(PE_NUM), set o_error=1 and go to DONE without touching the QEA.
REQ-019 SHALL set row count N = 2^(qbit_num - log2(PE_NUM)); qbit_num = log2(PE_NUM) gives N=1.
REQ-020 SHALL in LOAD_CTX assert o_ctx_ready; each i_ctx_valid&o_ctx_ready beat drives o_ctx_en=o_ctx_wea=1 the next cycle, address 0,1,... incrementing; exit after i_ins_num beats; i_ins_num=0 skips LOAD_CTX.
REQ-021 SHALL in LOAD_ST assert o_st_ready; each beat writes one row, o_state_ena=o_state_wea=all ones, addresses 0..N-1; exit after N beats.
REQ-022 SHALL pulse o_qea_start for exactly one cycle in START; clear and start o_exec_cycles.
REQ-023 SHALL in RUN increment o_exec_cycles per cycle (saturating at all ones) until i_qea_complete=1, then freeze it.
REQ-024 SHALL read back rows 0..N-1: RD_REQ drives o_state_ena=all ones, o_state_wea=0; RD_WAIT covers one-cycle RAM latency; RD_OUT registers i_qea_state_dout and holds o_rd_valid until i_rd_ready.
REQ-025 SHALL hold o_rd_data stable while o_rd_valid=1 and i_rd_ready=0.
REQ-026 SHALL in DONE assert o_done=1 until next accepted i_go; o_busy=1 in every state except IDLE and DONE.
REQ-027 SHALL deassert all QEA enables, write-enables and handshake readies outside their owning states.

Reset
REQ-028 SHALL on rst force IDLE and zero every output, counter and latched field, immediately and asynchronously.
REQ-029 SHALL, on rst mid-sequence, abandon the operation; partial RAM contents are not restored; next i_go restarts from LOAD_CTX.

Configuration
REQ-030 SHALL, with QEA_SEQ_TIMEOUT_EN defined, exit RUN to DONE with o_error=1 when o_exec_cycles reaches parameter TIMEOUT_CYCLES (default 2^20) without i_qea_complete, skipping readback.
REQ-031 SHALL, without QEA_SEQ_TIMEOUT_EN, wait in RUN indefinitely; TIMEOUT_CYCLES is unused.

Verification
REQ-032 SHALL check: i_go, qbit_num=4, ins_num=3, all streams ready -> ctx addrs 0,1,2 written; state rows 0..3 written; one o_qea_start pulse.
REQ-033 SHALL check: i_qea_complete asserted 100 cycles after start -> o_exec_cycles=100; 4 readback rows in address order; o_done=1.
REQ-034 SHALL check: i_rd_ready held low 5 cycles on row 2 -> o_rd_data unchanged, no address advance.
REQ-035 SHALL check: i_go with qbit_num=1 -> o_error=1, o_done=1, no o_ctx_en/o_state_ena activity.
REQ-036 SHALL check: rst asserted in LOAD_ST -> all outputs 0 same cycle; subsequent i_go completes normally.
REQ-037 SHALL check, QEA_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=50, no complete -> o_error=1 at cycle 50, no readback.

Source files
------------

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: loads context/state RAMs, starts the QEA, reads results back; QEA_SEQ_TIMEOUT_EN enables a RUN watchdog
module qea_host_sequencer #(
    parameter int PE_NUM = 4,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH = 6,
    parameter int CYC_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    input  logic                                 i_st_valid,
    output logic                                 o_st_ready,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_st_data,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_error,
    output logic [CYC_WIDTH-1:0]                 o_exec_cycles,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
);
    localparam int LOG_PE = $clog2(PE_NUM);
    localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
`ifdef QEA_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    typedef enum logic [3:0] {IDLE, LOAD_CTX, LOAD_ST, START, RUN, RD_REQ, RD_WAIT, RD_OUT, DONE} state_t;
    state_t state, state_nxt;
    logic [MAX_QBIT_WIDTH-1:0] qbit_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q, ctx_cnt, ctx_addr_q;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q;
    logic [STATE_ADDR_WIDTH-1:0] row_last, row, st_addr_q;
    logic [STATE_ADDR_WIDTH:0] rows_n;
    logic [ROW_W-1:0] st_din_q, rd_data_q;
    logic [CYC_WIDTH-1:0] exec_q;
    logic error_q, ctx_we_q, st_we_q;
    logic go_ok, qbit_ok, ctx_beat, st_beat, timeout, counting;
    assign go_ok = i_go && (state == IDLE || state == DONE);
    assign qbit_ok = int'(i_qbit_num) >= LOG_PE && int'(i_qbit_num) <= STATE_ADDR_WIDTH + LOG_PE;
    assign rows_n = (STATE_ADDR_WIDTH+1)'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(LOG_PE));
    assign ctx_beat = state == LOAD_CTX && i_ctx_valid;
    assign st_beat = state == LOAD_ST && i_st_valid;
    assign timeout = TO_EN && exec_q >= CYC_WIDTH'(TIMEOUT_CYCLES);
    assign counting = state == START || (state == RUN && !i_qea_complete && !timeout);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (i_go) state_nxt = !qbit_ok ? DONE : (i_ins_num != '0 ? LOAD_CTX : LOAD_ST);
            LOAD_CTX:   if (ctx_beat && ctx_cnt == ins_q - GATE_CONTEXT_ADDR_WIDTH'(1)) state_nxt = LOAD_ST;
            LOAD_ST:    if (st_beat && row == row_last) state_nxt = START;
            START:      state_nxt = RUN;
            RUN:        state_nxt = i_qea_complete ? RD_REQ : (timeout ? DONE : RUN);
            RD_REQ:     state_nxt = RD_WAIT;
            RD_WAIT:    state_nxt = RD_OUT;
            RD_OUT:     if (i_rd_ready) state_nxt = row == row_last ? DONE : RD_REQ;
            default:    state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qbit_q <= '0;
            ins_q <= '0;
            ctx_cnt <= '0;
            ctx_addr_q <= '0;
            ctx_data_q <= '0;
            row_last <= '0;
            row <= '0;
            st_addr_q <= '0;
            st_din_q <= '0;
            rd_data_q <= '0;
            exec_q <= '0;
            error_q <= 1'b0;
            ctx_we_q <= 1'b0;
            st_we_q <= 1'b0;
        end else begin
            ctx_we_q <= ctx_beat;
            st_we_q <= st_beat;
            if (go_ok) begin
                qbit_q <= i_qbit_num;
                ins_q <= i_ins_num;
                row_last <= STATE_ADDR_WIDTH'(rows_n - (STATE_ADDR_WIDTH+1)'(1));
                error_q <= !qbit_ok;
                exec_q <= '0;
                ctx_cnt <= '0;
                row <= '0;
            end
            if (ctx_beat) begin
                ctx_addr_q <= ctx_cnt;
                ctx_data_q <= i_ctx_data;
                ctx_cnt <= ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
            end
            if (st_beat) begin
                st_addr_q <= row;
                st_din_q <= i_st_data;
            end
            // row is shared: write address while loading, read address after START
            if (state == START) row <= '0;
            else if (st_beat || (state == RD_OUT && i_rd_ready)) row <= row + STATE_ADDR_WIDTH'(1);
            if (state == RD_WAIT) rd_data_q <= i_qea_state_dout;
            if (counting && exec_q != '1) exec_q <= exec_q + CYC_WIDTH'(1);
            if (state == RUN && !i_qea_complete && timeout) error_q <= 1'b1;
        end
    end
    assign o_busy = state != IDLE && state != DONE;
    assign o_done = state == DONE;
    assign o_error = error_q;
    assign o_exec_cycles = exec_q;
    assign o_ctx_ready = state == LOAD_CTX;
    assign o_st_ready = state == LOAD_ST;
    assign o_rd_valid = state == RD_OUT;
    assign o_rd_data = rd_data_q;
    assign o_qea_start = state == START;
    assign o_qea_qbit_num = qbit_q;
    assign o_ctx_en = ctx_we_q;
    assign o_ctx_wea = ctx_we_q;
    assign o_ctx_addr = ctx_addr_q;
    assign o_ctx_data = ctx_data_q;
    assign o_state_ena = {PE_NUM{st_we_q || state == RD_REQ}};
    assign o_state_wea = {PE_NUM{st_we_q}};
    assign o_state_addra = state == RD_REQ ? row : st_addr_q;
    assign o_state_dina = st_din_q;
endmodule

// File: tb/tb_qea_host_sequencer.sv
// tb_qea_host_sequencer: directed bench with RAM/QEA stand-ins and a queue scoreboard of expected writes and readback rows
`timescale 1ns/1ps
module tb_qea_host_sequencer;
    localparam int PE = 4, DW = 64, RW = PE * DW, AW = 16, CW = 64, CAW = 16, QW = 6, YW = 32, LOG_PE = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic i_go = 0, i_ctx_valid = 0, i_st_valid = 0, i_rd_ready = 1, i_qea_complete = 0;
    logic [QW-1:0] i_qbit_num = '0;
    logic [CAW-1:0] i_ins_num = '0;
    logic [CW-1:0] i_ctx_data = '0;
    logic [RW-1:0] i_st_data = '0, i_qea_state_dout = '0;
    logic o_ctx_ready, o_st_ready, o_rd_valid, o_busy, o_done, o_error, o_qea_start, o_ctx_en, o_ctx_wea;
    logic [RW-1:0] o_rd_data, o_state_dina;
    logic [YW-1:0] o_exec_cycles;
    logic [QW-1:0] o_qea_qbit_num;
    logic [CAW-1:0] o_ctx_addr;
    logic [CW-1:0] o_ctx_data;
    logic [PE-1:0] o_state_ena, o_state_wea;
    logic [AW-1:0] o_state_addra;
    always #5 clk = ~clk;
    qea_host_sequencer #(.PE_NUM(PE), .STATE_DATA_WIDTH(DW), .STATE_ADDR_WIDTH(AW),
        .GATE_CONTEXT_DATA_WIDTH(CW), .GATE_CONTEXT_ADDR_WIDTH(CAW), .MAX_QBIT_WIDTH(QW),
        .CYC_WIDTH(YW), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
        .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_data(i_st_data),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_exec_cycles(o_exec_cycles),
        .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num), .o_ctx_en(o_ctx_en),
        .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout));

    // state RAM stand-in with one-cycle read latency
    logic [RW-1:0] mem [0:63];
    always @(posedge clk)
        if (|o_state_ena) begin
            if (|o_state_wea) mem[o_state_addra[5:0]] <= o_state_dina;
            else i_qea_state_dout <= mem[o_state_addra[5:0]];
        end

    int tests = 0, fails = 0;
    int ctx_seen = 0, st_seen = 0, rd_seen = 0, starts = 0;
    int ctx_next = 0, st_next = 0, rd_addr_next = 0;
    logic [CW-1:0] exp_ctx[$];
    logic [RW-1:0] exp_st[$], exp_rd[$];
    logic [RW-1:0] prev_data = '0;
    logic prev_hold = 0;

    task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected DUT activity", name);
    endtask

    task automatic give_up(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "bench aborted");
    endtask

    always @(negedge clk) begin
        if (rst) prev_hold = 0;
        else begin
            if (o_ctx_en) begin
                ctx_seen++;
                chk("ctx_wea", o_ctx_wea, 1);
                chk("ctx_addr", o_ctx_addr, ctx_next);
                if (exp_ctx.size() == 0) flag("ctx_extra");
                else chk("ctx_data", o_ctx_data, exp_ctx.pop_front());
                ctx_next++;
            end
            if (|o_state_wea) begin
                st_seen++;
                chk("st_ena", o_state_ena, {PE{1'b1}});
                chk("st_addr", o_state_addra, st_next);
                if (exp_st.size() == 0) flag("st_extra");
                else chk("st_data", o_state_dina, exp_st.pop_front());
                st_next++;
            end else if (|o_state_ena) begin
                chk("rd_ena", o_state_ena, {PE{1'b1}});
                chk("rd_addr", o_state_addra, rd_addr_next);
                rd_addr_next++;
            end
            if (o_rd_valid && prev_hold) chk("rd_hold", o_rd_data, prev_data);
            if (o_rd_valid && i_rd_ready) begin
                rd_seen++;
                if (exp_rd.size() == 0) flag("rd_extra");
                else chk("rd_data", o_rd_data, exp_rd.pop_front());
            end
            if (o_qea_start) starts++;
            prev_hold = o_rd_valid && !i_rd_ready;
            prev_data = o_rd_data;
        end
    end

    task automatic go(input int q, input int ins);
        exp_ctx.delete(); exp_st.delete(); exp_rd.delete();
        ctx_next = 0; st_next = 0; rd_addr_next = 0;
        @(posedge clk); #1;
        i_go = 1; i_qbit_num = QW'(q); i_ins_num = CAW'(ins);
        @(posedge clk); #1;
        i_go = 0;
    endtask

    task automatic feed_ctx(input int n, input logic [15:0] seed);
        logic [CW-1:0] w;
        int g;
        for (int k = 0; k < n; k++) begin
            w = {seed, 16'(k), 32'hC0DE_0000 + 32'(k)};
            exp_ctx.push_back(w);
            i_ctx_data = w; i_ctx_valid = 1;
            g = 0;
            do begin @(negedge clk); g++; end while (!o_ctx_ready && g < 100);
            if (!o_ctx_ready) give_up("ctx_ready_wait");
            @(posedge clk); #1;
        end
        i_ctx_valid = 0;
    endtask

    task automatic feed_rows(input int n, input logic [15:0] seed);
        logic [RW-1:0] r;
        int g;
        for (int k = 0; k < n; k++) begin
            r = {4{seed, 16'(k), 32'(k * 977 + 5)}};
            exp_st.push_back(r); exp_rd.push_back(r);
            i_st_data = r; i_st_valid = 1;
            g = 0;
            do begin @(negedge clk); g++; end while (!o_st_ready && g < 100);
            if (!o_st_ready) give_up("st_ready_wait");
            @(posedge clk); #1;
        end
        i_st_valid = 0;
    endtask

    task automatic qea(input int lat);
        int g = 0;
        do begin @(negedge clk); g++; end while (!o_qea_start && g < 100);
        if (!o_qea_start) give_up("qea_start_wait");
        repeat (lat) @(posedge clk);
        #1 i_qea_complete = 1;
        @(posedge clk); #1 i_qea_complete = 0;
    endtask

    task automatic read_back(input int n, input int stall_row, input int stall_n);
        int g;
        for (int r = 0; r < n; r++) begin
            i_rd_ready = (r != stall_row);
            g = 0;
            do begin @(negedge clk); g++; end while (!o_rd_valid && g < 100);
            if (!o_rd_valid) give_up("rd_valid_wait");
            if (r == stall_row) begin
                for (int s = 1; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_valid", o_rd_valid, 1);
                    chk("stall_no_req", o_state_ena, 0);
                end
                @(posedge clk); #1 i_rd_ready = 1;
                @(negedge clk);
            end
            @(posedge clk); #1;
        end
        i_rd_ready = 1;
    endtask

    task automatic wait_done(input int budget);
        int g = 0;
        do begin @(negedge clk); g++; end while (!o_done && g < budget);
        if (!o_done) give_up("done_wait");
    endtask

    task automatic run_op(input int q, input int ins, input int lat, input int stall_row, input int stall_n, input logic [15:0] seed);
        int n, c0, s0, r0, t0;
        n = 1 << (q - LOG_PE);
        c0 = ctx_seen; s0 = st_seen; r0 = rd_seen; t0 = starts;
        go(q, ins);
        chk("busy_after_go", o_busy, 1);
        feed_ctx(ins, seed);
        feed_rows(n, seed);
        qea(lat);
        read_back(n, stall_row, stall_n);
        wait_done(50);
        chk("done", o_done, 1);
        chk("error_clear", o_error, 0);
        chk("busy_in_done", o_busy, 0);
        chk("exec_cycles", o_exec_cycles, lat);
        chk("qbit_out", o_qea_qbit_num, q);
        chk("ctx_writes", ctx_seen - c0, ins);
        chk("st_writes", st_seen - s0, n);
        chk("rd_rows", rd_seen - r0, n);
        chk("start_pulses", starts - t0, 1);
        chk("rd_queue_left", exp_rd.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {o_busy, o_done, o_error, o_ctx_ready, o_st_ready, o_rd_valid, o_qea_start,
            o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea}, 0);
        chk({tag, "_fields"}, {o_exec_cycles, o_qea_qbit_num, o_ctx_addr, o_state_addra}, 0);
        chk({tag, "_ctx_data"}, o_ctx_data, 0);
        chk({tag, "_rd_data"}, o_rd_data, 0);
        chk({tag, "_dina"}, o_state_dina, 0);
    endtask

    initial begin
        int c0, s0, t0, r0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst = 0;
        // qbit=4 -> 4 rows, 3 context words, 100-cycle run, row 2 stalled 5 cycles
        run_op(4, 3, 100, 2, 5, 16'h1111);
        chk("exec_100_literal", o_exec_cycles, 32'd100);
        chk("ctx_count_literal", ctx_seen, 3);
        chk("row_count_literal", st_seen, 4);
        chk("last_ctx_addr_literal", o_ctx_addr, 2);
        // out-of-range qubit counts must not touch the QEA
        c0 = ctx_seen; s0 = st_seen; t0 = starts;
        go(1, 0);
        wait_done(10);
        chk("bad_q1_error", o_error, 1);
        chk("bad_q1_done", o_done, 1);
        go(19, 5);
        wait_done(10);
        repeat (3) @(posedge clk);
        #1 chk("bad_q19_error", o_error, 1);
        chk("bad_q19_busy", o_busy, 0);
        chk("bad_no_ctx", ctx_seen - c0, 0);
        chk("bad_no_state", st_seen - s0, 0);
        chk("bad_no_start", starts - t0, 0);
        // smallest legal size: one row, no context
        run_op(2, 0, 7, -1, 0, 16'h2222);
        // reset while loading state rows
        go(3, 1);
        feed_ctx(1, 16'h5555);
        feed_rows(1, 16'h5555);
        @(posedge clk); #3 rst = 1;
        #1 chk_zero("mid_reset");
        @(posedge clk); #1 rst = 0;
        run_op(3, 2, 20, 0, 2, 16'h3333);
`ifdef QEA_SEQ_TIMEOUT_EN
        r0 = rd_seen;
        go(2, 0);
        feed_rows(1, 16'h4444);
        wait_done(200);
        chk("timeout_error", o_error, 1);
        chk("timeout_cycles", o_exec_cycles, 32'd50);
        repeat (4) @(posedge clk);
        #1 chk("timeout_no_readback", rd_seen - r0, 0);
`else
        r0 = rd_seen;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
